// File: rtl/ca_gen_ctrl_if.sv
// ca_gen_ctrl_if
// Frame-buffer row port shared between the display reader and the
// generation engine. One row word moves per access.
//   mem_addr   row address presented to the frame buffer
//   mem_we     write strobe for the row at mem_addr
//   mem_wdata  row word to be written
//   mem_rdata  row word read back, valid one cycle after the address
// The master modport belongs to ca_gen_ctrl. The slave modport belongs
// to the frame buffer.
interface ca_gen_ctrl_if #(
   parameter int COLS = 80,
   parameter int AW   = 6
);
   logic [AW-1:0]   mem_addr;
   logic            mem_we;
   logic [COLS-1:0] mem_wdata;
   logic [COLS-1:0] mem_rdata;

   modport master (
      output mem_addr,
      output mem_we,
      output mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_we,
      input  mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/ca_gen_ctrl.sv
// ca_gen_ctrl
// Generation controller and port arbiter for the cellular-automaton frame
// buffer. The block shares the single frame-buffer port between the display
// reader and its own update engine.
//
// On an accepted step, the engine does the following:
//   1. Reads the newest row.
//   2. Applies the latched Wolfram rule, with the columns wrapping round.
//   3. Overwrites the oldest row.
//   4. Advances the circular top-row pointer, so the display scrolls by one row.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   enable       allows step to be accepted
//   step         one-cycle request to compute one generation
//   rule         Wolfram rule number, latched when step is accepted
//   disp_req     display wants the port this cycle (absolute priority)
//   disp_row     logical screen row, 0 = top of screen
//   mem          frame-buffer port (ca_gen_ctrl_if master)
//   busy         high while an update is in progress
//   top_row      physical row shown at screen row 0
//   gen_count    generations written, wraps at 2^16
module ca_gen_ctrl #(
   parameter int ROWS = 60,
   parameter int COLS = 80,
   parameter int AW   = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          step,
   input  logic [7:0]    rule,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_row,
   ca_gen_ctrl_if.master mem,
   output logic          busy,
   output logic [AW-1:0] top_row,
   output logic [15:0]   gen_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
   localparam logic [1:0] CAP  = 2'd2;
   localparam logic [1:0] WR   = 2'd3;

   localparam logic [AW:0]   ROWS_EXT = (AW+1)'(ROWS);
   localparam logic [AW-1:0] LAST_ROW = AW'(ROWS-1);

   logic [1:0]      state_q, state_d;
   logic [AW-1:0]   topRow_q, topRow_d;
   logic [15:0]     genCount_q, genCount_d;
   logic [7:0]      rule_q, rule_d;
   logic [COLS-1:0] wdata_q, wdata_d;

   logic [AW:0]     physSum;
   logic [AW-1:0]   physAddr;
   logic [AW-1:0]   newestRow;
   logic [COLS+1:0] wrapRow;
   logic [COLS-1:0] nextRow;

   // Map the logical display row onto the circular buffer. disp_row is
   // always below ROWS, so one conditional subtract replaces the modulo.
   always_comb begin
      physSum  = {1'b0, topRow_q} + {1'b0, disp_row};
      physAddr = physSum[AW-1:0];
      if (physSum >= ROWS_EXT) begin
         physAddr = AW'(physSum - ROWS_EXT);
      end
   end

   // The newest generation sits just above the top row, circularly.
   assign newestRow = (topRow_q == '0) ? LAST_ROW : topRow_q - AW'(1);

   // Pad the row with its wrapped neighbours. Bit 0 gets column COLS-1 to
   // its right, and bit COLS-1 gets column 0 to its left. A 3-bit window
   // at position i is then {left, centre, right} for column i.
   assign wrapRow = {mem.mem_rdata[0], mem.mem_rdata, mem.mem_rdata[COLS-1]};

   // Apply the Wolfram rule to every column of the row just read.
   always_comb begin
      nextRow = '0;
      for (int i = 0; i < COLS; i++) begin
         nextRow[i] = rule_q[wrapRow[i +: 3]];
      end
   end

   // Port arbitration. The display always wins. The engine drives the
   // address only in the RD and WR cycles. The write strobe is masked by
   // reset, so an aborted update never reaches the frame buffer.
   always_comb begin
      mem.mem_addr = physAddr;
      if (!disp_req) begin
         case (state_q)
            RD:      mem.mem_addr = newestRow;
            WR:      mem.mem_addr = topRow_q;
            default: mem.mem_addr = physAddr;
         endcase
      end
   end

   assign mem.mem_we    = (state_q == WR) && !disp_req && !rst;
   assign mem.mem_wdata = wdata_q;
   assign busy          = (state_q != IDLE);
   assign top_row       = topRow_q;
   assign gen_count     = genCount_q;

   // Update sequencing. RD and WR wait for a cycle in which the display is
   // not using the port. CAP never waits, because the read data is only
   // valid in the cycle straight after RD. Steps that arrive while busy
   // are dropped, not queued.
   always_comb begin
      state_d    = state_q;
      topRow_d   = topRow_q;
      genCount_d = genCount_q;
      rule_d     = rule_q;
      wdata_d    = wdata_q;
      case (state_q)
         IDLE: begin
            if (step && enable) begin
               rule_d  = rule;
               state_d = RD;
            end
         end
         RD: begin
            if (!disp_req) begin
               state_d = CAP;
            end
         end
         CAP: begin
            wdata_d = nextRow;
            state_d = WR;
         end
         WR: begin
            if (!disp_req) begin
               topRow_d   = (topRow_q == LAST_ROW) ? '0 : topRow_q + AW'(1);
               genCount_d = genCount_q + 16'd1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         topRow_q   <= '0;
         genCount_q <= '0;
         rule_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         topRow_q   <= topRow_d;
         genCount_q <= genCount_d;
         rule_q     <= rule_d;
         wdata_q    <= wdata_d;
      end
   end

endmodule

// File: tb/tb_ca_gen_ctrl.sv
// tb_ca_gen_ctrl
// Randomised bench for ca_gen_ctrl.
// The bench models the frame buffer and keeps a reference copy of the
// expected frame contents, the top-row pointer and the generation count.
// Expected rows come from the cellular-automaton rule, computed with
// modular column arithmetic.
module tb_ca_gen_ctrl;

   localparam int ROWS = 60;
   localparam int COLS = 80;
   localparam int AW   = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          step;
   logic [7:0]    rule;
   logic          disp_req;
   logic [AW-1:0] disp_row;
   logic          busy;
   logic [AW-1:0] top_row;
   logic [15:0]   gen_count;

   int checks = 0;
   int errors = 0;

   ca_gen_ctrl_if #(.COLS(COLS), .AW(AW)) memIf ();

   ca_gen_ctrl #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .step     (step),
      .rule     (rule),
      .disp_req (disp_req),
      .disp_row (disp_row),
      .mem      (memIf),
      .busy     (busy),
      .top_row  (top_row),
      .gen_count(gen_count)
   );

   always #5 clk = ~clk;

   // Frame-buffer model with a one-cycle read latency. The preload path
   // lets the bench seed rows while the controller is idle.
   logic [COLS-1:0] memArr [ROWS];
   logic            plEn;
   logic [AW-1:0]   plRow;
   logic [COLS-1:0] plData;

   always @(posedge clk) begin
      if (plEn) begin
         memArr[plRow] <= plData;
      end else if (memIf.mem_we) begin
         memArr[memIf.mem_addr] <= memIf.mem_wdata;
      end
      memIf.mem_rdata <= memArr[memIf.mem_addr];
   end

   // Reference model state.
   logic [COLS-1:0] refMem [ROWS];
   int mTop;
   int mGen;

   function automatic logic [COLS-1:0] caNext(input logic [COLS-1:0] old, input logic [7:0] r);
      logic [COLS-1:0] res;
      res = '0;
      for (int i = 0; i < COLS; i++) begin
         int l;
         int rr;
         int idx;
         l   = (i + 1) % COLS;
         rr  = (i + COLS - 1) % COLS;
         idx = int'(old[l]) * 4 + int'(old[i]) * 2 + int'(old[rr]);
         res[i] = r[idx];
      end
      return res;
   endfunction

   function automatic int phys(input int top, input int r);
      return (top + r) % ROWS;
   endfunction

   task automatic preload(input int row, input logic [COLS-1:0] data);
      plEn   = 1'b1;
      plRow  = AW'(row);
      plData = data;
      @(posedge clk);
      #1;
      plEn = 1'b0;
      refMem[row] = data;
   endtask

   // Issue one step and follow it to completion. The display holds the
   // port for rdStall cycles during RD and for wrStall cycles during WR.
   // With noise set, step and rule are toggled while the update is busy.
   task automatic run_step(input logic [7:0] r, input int rdStall, input int wrStall,
                           input bit noise, output logic [COLS-1:0] got);
      int newest;
      int wrCycle;
      logic [COLS-1:0] exp;
      newest  = (mTop + ROWS - 1) % ROWS;
      exp     = caNext(refMem[newest], r);
      wrCycle = rdStall + 3 + wrStall;
      got     = '0;
      step     = 1'b1;
      rule     = r;
      disp_req = 1'b0;
      @(posedge clk);
      #1;
      for (int c = 1; c <= wrCycle; c++) begin
         disp_row = AW'($urandom_range(0, ROWS - 1));
         if (c <= rdStall || (c > rdStall + 2 && c < wrCycle)) begin
            disp_req = 1'b1;
         end else if (c == rdStall + 2) begin
            disp_req = 1'($urandom_range(0, 1));
         end else begin
            disp_req = 1'b0;
         end
         step = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         rule = 8'($urandom);
         @(negedge clk);
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_during_step cycle %0d: got %b want 1", c, busy);
         end
         if (disp_req || c == rdStall + 2) begin
            checks++;
            if (memIf.mem_addr !== AW'(phys(mTop, int'(disp_row)))) begin
               errors++;
               $display("[TB] FAIL disp_addr cycle %0d: got %0d want %0d", c, memIf.mem_addr, phys(mTop, int'(disp_row)));
            end
         end
         if (c == rdStall + 1) begin
            checks++;
            if (memIf.mem_addr !== AW'(newest)) begin
               errors++;
               $display("[TB] FAIL read_addr: got %0d want %0d", memIf.mem_addr, newest);
            end
         end
         if (c == wrCycle) begin
            checks++;
            if (memIf.mem_we !== 1'b1 || memIf.mem_addr !== AW'(mTop) || memIf.mem_wdata !== exp) begin
               errors++;
               $display("[TB] FAIL write: we %b addr %0d data %h want we 1 addr %0d data %h",
                        memIf.mem_we, memIf.mem_addr, memIf.mem_wdata, mTop, exp);
            end
            got = memIf.mem_wdata;
         end else begin
            checks++;
            if (memIf.mem_we !== 1'b0) begin
               errors++;
               $display("[TB] FAIL early_write cycle %0d: got we %b want 0", c, memIf.mem_we);
            end
         end
         @(posedge clk);
         #1;
      end
      step     = 1'b0;
      disp_req = 1'b0;
      refMem[mTop] = exp;
      mTop = (mTop + 1) % ROWS;
      mGen = (mGen + 1) % 65536;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || top_row !== AW'(mTop) || gen_count !== 16'(mGen) || memIf.mem_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL after_step: busy %b top %0d gen %0d we %b want busy 0 top %0d gen %0d we 0",
                  busy, top_row, gen_count, memIf.mem_we, mTop, mGen);
      end
      checks++;
      if (memIf.mem_addr !== AW'(phys(mTop, int'(disp_row)))) begin
         errors++;
         $display("[TB] FAIL idle_addr: got %0d want %0d", memIf.mem_addr, phys(mTop, int'(disp_row)));
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      enable   = 1'b1;
      step     = 1'b0;
      rule     = 8'd0;
      disp_req = 1'b0;
      disp_row = AW'(5);
      plEn     = 1'b0;
      plRow    = '0;
      plData   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      mTop = 0;
      mGen = 0;
      @(negedge clk);
      checks++;
      if (top_row !== '0) begin errors++; $display("[TB] FAIL reset_top: got %0d want 0", top_row); end
      checks++;
      if (gen_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_gen: got %0d want 0", gen_count); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (memIf.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b want 0", memIf.mem_we); end
      checks++;
      if (memIf.mem_wdata !== '0) begin errors++; $display("[TB] FAIL reset_wdata: got %h want 0", memIf.mem_wdata); end
      checks++;
      if (memIf.mem_addr !== AW'(5)) begin errors++; $display("[TB] FAIL reset_addr: got %0d want 5", memIf.mem_addr); end
   endtask

   task automatic test_single_rule90();
      logic [COLS-1:0] got;
      logic [COLS-1:0] seed;
      logic [COLS-1:0] want;
      for (int i = 0; i < ROWS - 1; i++) preload(i, '0);
      seed = '0;
      seed[40] = 1'b1;
      preload(ROWS - 1, seed);
      run_step(8'd90, 0, 0, 1'b0, got);
      want = '0;
      want[39] = 1'b1;
      want[41] = 1'b1;
      checks++;
      if (got !== want) begin errors++; $display("[TB] FAIL rule90_row: got %h want %h", got, want); end
      checks++;
      if (top_row !== AW'(1) || gen_count !== 16'd1) begin
         errors++;
         $display("[TB] FAIL rule90_counters: top %0d gen %0d want top 1 gen 1", top_row, gen_count);
      end
   endtask

   task automatic test_column_wrap();
      logic [COLS-1:0] got;
      logic [COLS-1:0] seed;
      logic [COLS-1:0] want;
      seed = '0;
      seed[0] = 1'b1;
      preload((mTop + ROWS - 1) % ROWS, seed);
      run_step(8'd90, 0, 0, 1'b0, got);
      want = '0;
      want[79] = 1'b1;
      want[1]  = 1'b1;
      checks++;
      if (got !== want) begin errors++; $display("[TB] FAIL wrap_rule90: got %h want %h", got, want); end
      preload((mTop + ROWS - 1) % ROWS, seed);
      run_step(8'd30, 0, 0, 1'b0, got);
      want = '0;
      want[79] = 1'b1;
      want[1]  = 1'b1;
      want[0]  = 1'b1;
      checks++;
      if (got !== want) begin errors++; $display("[TB] FAIL wrap_rule30: got %h want %h", got, want); end
   endtask

   task automatic test_contention();
      logic [COLS-1:0] got;
      for (int i = 0; i < ROWS; i++) preload(i, {16'($urandom), 32'($urandom), 32'($urandom)});
      run_step(8'($urandom), 4, 4, 1'b0, got);
      for (int n = 0; n < 4; n++) begin
         run_step(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, got);
      end
   endtask

   task automatic test_ignored();
      logic [COLS-1:0] got;
      int genBefore;
      int topBefore;
      run_step(8'($urandom), 1, 2, 1'b1, got);
      run_step(8'($urandom), 0, 0, 1'b1, got);
      genBefore = mGen;
      topBefore = mTop;
      enable = 1'b0;
      step   = 1'b1;
      rule   = 8'($urandom);
      @(posedge clk);
      #1;
      step = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || memIf.mem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disabled_step cycle %0d: busy %b we %b want 0 0", c, busy, memIf.mem_we);
         end
      end
      enable = 1'b1;
      checks++;
      if (gen_count !== 16'(genBefore) || top_row !== AW'(topBefore)) begin
         errors++;
         $display("[TB] FAIL disabled_counters: top %0d gen %0d want top %0d gen %0d",
                  top_row, gen_count, topBefore, genBefore);
      end
   endtask

   task automatic test_abort();
      step     = 1'b1;
      rule     = 8'($urandom);
      disp_req = 1'b0;
      @(posedge clk);
      #1;
      step = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (memIf.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL abort_we_in_reset: got %b want 0", memIf.mem_we); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      mTop = 0;
      mGen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (memIf.mem_we !== 1'b0 || busy !== 1'b0 || top_row !== '0 || gen_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL abort_after cycle %0d: we %b busy %b top %0d gen %0d want 0 0 0 0",
                     c, memIf.mem_we, busy, top_row, gen_count);
         end
      end
   endtask

   task automatic test_row_wrap();
      logic [COLS-1:0] got;
      for (int n = 0; n < ROWS - 1; n++) begin
         run_step(8'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), 1'b0, got);
      end
      disp_row = AW'(1);
      disp_req = 1'b1;
      @(negedge clk);
      checks++;
      if (top_row !== AW'(59) || memIf.mem_addr !== AW'(0)) begin
         errors++;
         $display("[TB] FAIL top59_addr: top %0d addr %0d want top 59 addr 0", top_row, memIf.mem_addr);
      end
      disp_req = 1'b0;
      run_step(8'($urandom), 0, 0, 1'b0, got);
      checks++;
      if (top_row !== '0 || gen_count !== 16'd60) begin
         errors++;
         $display("[TB] FAIL row_wrap_end: top %0d gen %0d want top 0 gen 60", top_row, gen_count);
      end
   endtask

   initial begin
      test_reset();
      test_single_rule90();
      test_column_wrap();
      test_contention();
      test_ignored();
      test_abort();
      test_row_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
